vpu_sram_rd_responder: RTL and testbench

VPU_SRAM_RD_RESPONDER -- requirements
Module: vpu_sram_rd_responder

---
 rtl/vpu_pkg.sv | 15 +
 rtl/vpu_sram_rd_lat_pipe.sv | 35 +++
 rtl/vpu_sram_rd_responder.sv | 128 ++++++++++++
 tb/tb_vpu_sram_rd_responder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared SRAM geometry and read-responder state type
package vpu_pkg;

    localparam int SRAM_DATA_WIDTH     = 32;
    localparam int SRAM_BANK_CNT_LG2   = 2;
    localparam int SRAM_BANK_DEPTH_LG2 = 10;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BURST,
        DRAIN
    } vpu_sram_rd_state_t;

endpackage

// File: rtl/vpu_sram_rd_lat_pipe.sv
// rtl/vpu_sram_rd_lat_pipe.sv - valid shift pipeline matching the SRAM macro read latency
module vpu_sram_rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic out_valid,
    output logic empty
);

    logic [DEPTH-1:0] stage;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk) begin
            if (rst) begin
                stage <= '0;
            end else begin
                stage <= in_valid;
            end
        end
    end else begin : g_shift
        always_ff @(posedge clk) begin
            if (rst) begin
                stage <= '0;
            end else begin
                stage <= {stage[DEPTH-2:0], in_valid};
            end
        end
    end

    assign out_valid = stage[DEPTH-1];
    assign empty     = (stage == '0);

endmodule

// File: rtl/vpu_sram_rd_responder.sv
// rtl/vpu_sram_rd_responder.sv - banked SRAM read-burst responder; VPU_SRAM_RD_OUTREG_EN adds an output register stage
module vpu_sram_rd_responder
    import vpu_pkg::*;
#(
    parameter int RD_LAT = 1,
    localparam int DW    = SRAM_DATA_WIDTH,
    localparam int BCL   = SRAM_BANK_CNT_LG2,
    localparam int ADL   = SRAM_BANK_DEPTH_LG2,
    localparam int BANKS = 2 ** BCL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rreq_i,
    input  logic [BCL-1:0]      rid_i,
    input  logic [ADL-1:0]      raddr_i,
    input  logic                reb_i,
    input  logic                rlast_i,
    output logic                rack_o,
    output logic [DW-1:0]       rdata_o,
    output logic                rvalid_o,
    input  logic [BANKS-1:0]    bank_avail_i,
    output logic [BANKS-1:0]    sram_ce_o,
    output logic [ADL-1:0]      sram_addr_o,
    input  logic [DW*BANKS-1:0] sram_rdata_i,
    output logic                busy_o
);

    vpu_sram_rd_state_t state, state_d;
    logic [BCL-1:0]     bank_q;
    logic               issue;
    logic               pipe_valid;
    logic               pipe_empty;
    logic               drained;
    logic [DW-1:0]      sel_data;

    assign issue       = (state == BURST) && rreq_i && !reb_i;
    assign sram_addr_o = raddr_i;
    assign busy_o      = (state != IDLE);

    vpu_sram_rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .out_valid (pipe_valid),
        .empty     (pipe_empty)
    );

    always_comb begin
        sel_data = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (bank_q == BCL'(b)) begin
                sel_data = sram_rdata_i[b*DW +: DW];
            end
        end
    end

`ifdef VPU_SRAM_RD_OUTREG_EN
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pipe_valid;
            rdata_q  <= pipe_valid ? sel_data : '0;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign drained  = pipe_empty && !rvalid_q;
`else
    assign rvalid_o = pipe_valid;
    assign rdata_o  = pipe_valid ? sel_data : '0;
    assign drained  = pipe_empty;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bank_q <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && state_d == GRANT) begin
                bank_q <= rid_i;
            end
        end
    end

    // Abort (rreq_i low) takes priority over a strobe in the same cycle.
    always_comb begin
        state_d   = state;
        rack_o    = 1'b0;
        sram_ce_o = '0;
        case (state)
            IDLE: begin
                if (rreq_i && bank_avail_i[rid_i]) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                rack_o  = 1'b1;
                state_d = BURST;
            end
            BURST: begin
                if (!rreq_i) begin
                    state_d = DRAIN;
                end else if (!reb_i) begin
                    sram_ce_o = BANKS'(1) << bank_q;
                    if (rlast_i) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vpu_sram_rd_responder.sv
// tb/tb_vpu_sram_rd_responder.sv - scoreboard bench over RD_LAT 1..3 instances sharing one stimulus stream
module tb_vpu_sram_rd_responder;
    import vpu_pkg::*;

    localparam int NI    = 3;
    localparam int DW    = SRAM_DATA_WIDTH;
    localparam int BCL   = SRAM_BANK_CNT_LG2;
    localparam int ADL   = SRAM_BANK_DEPTH_LG2;
    localparam int BANKS = 2 ** BCL;
`ifdef VPU_SRAM_RD_OUTREG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             rreq;
    logic             reb;
    logic             rlast;
    logic [BCL-1:0]   rid;
    logic [ADL-1:0]   raddr;
    logic [BANKS-1:0] avail;

    logic             rack   [NI];
    logic [DW-1:0]    rdata  [NI];
    logic             rvalid [NI];
    logic [BANKS-1:0] ce     [NI];
    logic [ADL-1:0]   saddr  [NI];
    logic             busy   [NI];

    function automatic logic [DW-1:0] mem_word(input int b, input logic [ADL-1:0] a);
        logic [DW-1:0] h;
        h = (DW'(a) + DW'(1)) * 32'h9e37_79b9;
        return h ^ DW'(b) ^ (DW'(b) << 28);
    endfunction

    // Each instance gets its own macro model whose data appears RD_LAT cycles after the enable.
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L = gi + 1;
        logic [DW*BANKS-1:0] macro_rdata;
        logic [BANKS-1:0]    ce_hist   [L];
        logic [ADL-1:0]      addr_hist [L];

        always @(posedge clk) begin
            ce_hist[0]   <= ce[gi];
            addr_hist[0] <= saddr[gi];
            for (int k = 1; k < L; k++) begin
                ce_hist[k]   <= ce_hist[k-1];
                addr_hist[k] <= addr_hist[k-1];
            end
        end

        always_comb begin
            macro_rdata = '0;
            for (int b = 0; b < BANKS; b++) begin
                macro_rdata[b*DW +: DW] = ce_hist[L-1][b] ? mem_word(b, addr_hist[L-1])
                                                          : ~mem_word(b, addr_hist[L-1]);
            end
        end

        vpu_sram_rd_responder #(
            .RD_LAT (L)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .rreq_i       (rreq),
            .rid_i        (rid),
            .raddr_i      (raddr),
            .reb_i        (reb),
            .rlast_i      (rlast),
            .rack_o       (rack[gi]),
            .rdata_o      (rdata[gi]),
            .rvalid_o     (rvalid[gi]),
            .bank_avail_i (avail),
            .sram_ce_o    (ce[gi]),
            .sram_addr_o  (saddr[gi]),
            .sram_rdata_i (macro_rdata),
            .busy_o       (busy[gi])
        );
    end

    // Reference model: protocol phases per instance plus the cycle each read must return.
    int             cyc = 0;
    bit             m_busy   [NI];
    bit             m_grant  [NI];
    bit             m_burst  [NI];
    logic [BCL-1:0] m_bank   [NI];
    int             last_arr [NI];
    beat_t          sbq      [NI][$];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_busy[i]   <= 1'b0;
                m_grant[i]  <= 1'b0;
                m_burst[i]  <= 1'b0;
                m_bank[i]   <= '0;
                last_arr[i] <= -1;
            end else if (!m_busy[i]) begin
                if (rreq && avail[rid]) begin
                    m_busy[i]  <= 1'b1;
                    m_grant[i] <= 1'b1;
                    m_bank[i]  <= rid;
                end
            end else if (m_grant[i]) begin
                m_grant[i] <= 1'b0;
                m_burst[i] <= 1'b1;
            end else if (m_burst[i]) begin
                if (!rreq) begin
                    m_burst[i] <= 1'b0;
                end else if (!reb) begin
                    sbq[i].push_back(beat_t'{cyc + i + 1 + EXTRA, mem_word(int'(m_bank[i]), raddr)});
                    last_arr[i] <= cyc + i + 1 + EXTRA;
                    if (rlast) m_burst[i] <= 1'b0;
                end
            end else if (last_arr[i] < cyc) begin
                m_busy[i] <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %0h want %0h", name, i, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [BANKS-1:0] exp_ce;
        if (cyc > 0) begin
            for (int i = 0; i < NI; i++) begin
                exp_ce = (m_burst[i] && rreq && !reb) ? (BANKS'(1) << m_bank[i]) : '0;
                chk("rack", i, 64'(rack[i]), 64'(m_grant[i]));
                chk("busy", i, 64'(busy[i]), 64'(m_busy[i]));
                chk("sram_ce", i, 64'(ce[i]), 64'(exp_ce));
                if (exp_ce != '0) chk("sram_addr", i, 64'(saddr[i]), 64'(raddr));
                if (rst) begin
                    sbq[i].delete();
                end else if (sbq[i].size() > 0 && sbq[i][0].cyc == cyc) begin
                    chk("rvalid", i, 64'(rvalid[i]), 64'd1);
                    if (rvalid[i]) chk("rdata", i, 64'(rdata[i]), 64'(sbq[i][0].data));
                    void'(sbq[i].pop_front());
                end else begin
                    chk("rvalid", i, 64'(rvalid[i]), 64'd0);
                    chk("rdata_idle", i, 64'(rdata[i]), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NI; i++) if (busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!all_idle()) begin
            tick();
            n++;
            if (n > 100) begin
                $display("FAIL wait_idle timeout at cyc %0d", cyc);
                $fatal(1, "bench stopped");
            end
        end
        avail = '1;
    endtask

    // Holds rreq until every instance has granted, then steps into the burst.
    task automatic request(input logic [BCL-1:0] bank);
        bit seen [NI];
        bit done;
        int n = 0;
        seen = '{default: 1'b0};
        rreq = 1'b1;
        rid  = bank;
        done = 1'b0;
        while (!done) begin
            tick();
            n++;
            done = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (rack[i]) seen[i] = 1'b1;
                if (!seen[i]) done = 1'b0;
            end
            if (n > 100) begin
                $display("FAIL request timeout at cyc %0d", cyc);
                $fatal(1, "bench stopped");
            end
        end
        rid   = BCL'($urandom);
        avail = BANKS'($urandom);
        tick();
    endtask

    task automatic reads(input int n, input int abort_at, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    reb   = 1'b1;
                    rlast = 1'($urandom);
                    raddr = ADL'($urandom);
                    avail = BANKS'($urandom);
                    tick();
                end
            end
            raddr = ADL'($urandom);
            avail = BANKS'($urandom);
            if (k == abort_at) begin
                rreq  = 1'b0;
                reb   = 1'($urandom);
                rlast = 1'($urandom);
                tick();
                break;
            end
            reb   = 1'b0;
            rlast = (k == n - 1);
            tick();
        end
        rreq  = 1'b0;
        reb   = 1'b1;
        rlast = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        rreq  = 1'b0;
        reb   = 1'b1;
        rlast = 1'b0;
        rid   = '0;
        raddr = '0;
        avail = '1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // single read from bank 2
        request(2'd2);
        raddr = 10'h010;
        reb   = 1'b0;
        rlast = 1'b1;
        tick();
        reb   = 1'b1;
        rlast = 1'b0;
        rreq  = 1'b0;
        wait_idle();

        // back-to-back 4-beat burst
        request(BCL'($urandom));
        reads(4, 99, 1'b0);
        wait_idle();

        // bank blocked for 5 cycles
        rreq     = 1'b1;
        rid      = 2'd1;
        avail    = '1;
        avail[1] = 1'b0;
        repeat (5) tick();
        avail[1] = 1'b1;
        request(2'd1);
        reads(2, 99, 1'b0);
        wait_idle();

        // abort after 2 of 4, new request raised straight away
        request(BCL'($urandom));
        reads(4, 2, 1'b0);
        avail = '1;
        request(BCL'($urandom));
        reads(1, 99, 1'b0);
        wait_idle();

        // reset with two reads in flight
        request(2'd0);
        reb = 1'b0;
        raddr = ADL'($urandom);
        tick();
        raddr = ADL'($urandom);
        tick();
        rst  = 1'b1;
        reb  = 1'b1;
        rreq = 1'b0;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        wait_idle();

        // randomized bursts with gaps, ignored rlast and occasional aborts
        repeat (25) begin
            request(BCL'($urandom));
            reads($urandom_range(1, 6), $urandom_range(0, 11), 1'b1);
            wait_idle();
        end

        repeat (6) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
